backend_multi_ch: RTL
=====================

// Module: backend_multi_ch
// PURPOSE
// - Next-gen backend config receiver: decodes serial frames from the FPGA (i_sclk/i_sdin) into NCH channels of gain + per-channel reset.
// - Generalises fixed 2-ch backend (gainA1/gainA2, resetb1/resetb2) to parametrised channel count/gain width, adds broadcast, timeout, error reporting.
// - Sits between FPGA_model serial link and analog channel controls; o_ready tells FPGA when frames may be sent.
// PARAMETERS
// - NCH          4    number of channels (>=2)
// - GW           3    gain bits per channel
// - ADDR_W       2    channel address bits; must satisfy 2**ADDR_W >= NCH
// - GAIN_RST     0    gain value on reset (all channels)
// - STARTUP_CYC  16   i_clk cycles after reset release before o_ready rises
// - TIMEOUT      64   i_clk cycles without sclk rising edge that abort a partial frame
// PORTS
// - i_clk        in   1        main clock, all logic rising-edge
// - i_resetbAll  in   1        async active-low reset
// - i_sclk       in   1        serial clock from FPGA, asynchronous, oversampled
// - i_sdin       in   1        serial data, valid around i_sclk rising edge
// - o_ready      out  1        receiver ready for frames
// - o_resetb     out  NCH      per-channel active-low reset, bit n = channel n
// - o_gain       out  NCH*GW   gains, channel n at [n*GW +: GW]
// - o_cfg_done   out  1        1-cycle pulse: valid frame applied
// - o_frame_err  out  1        1-cycle pulse: frame discarded
// BEHAVIOUR
// - Reset (async, i_resetbAll=0): o_ready=0, o_resetb=0 (all channels held), o_gain=all GAIN_RST, pulses 0, state STARTUP, bit count 0.
// - Input path: i_sclk, i_sdin each 2-flop synchronised; sclk rising edge = synced sclk 1 & prev 0; sdin sampled in same cycle.
//   Pin-to-capture latency 3 cycles. FPGA keeps sclk high and low each >=3 i_clk cycles.
// - Frame: FRAME_LEN = 2+ADDR_W+GW bits, MSB first: opcode[1:0], addr[ADDR_W-1:0], data[GW-1:0].
// - Opcodes: 00 write gain[addr]=data; 01 release o_resetb[addr]=1; 10 assert o_resetb[addr]=0; 11 broadcast gain[all]=data (addr ignored).
// - FSM:
//   STARTUP: count STARTUP_CYC cycles, o_ready=0, sclk edges ignored -> IDLE.
//   IDLE:    o_ready=1; sclk edge -> shift bit, count=1, SHIFT.
//   SHIFT:   o_ready=1; each edge shifts a bit and clears timeout counter; on edge making count==FRAME_LEN -> APPLY;
//            timeout counter reaching TIMEOUT -> o_frame_err pulse, clear count, IDLE.
//   APPLY:   one cycle; update registers, o_cfg_done pulse (or o_frame_err if invalid); -> IDLE.
//            An sclk edge in this cycle is captured as bit 1 of next frame -> SHIFT.
// - Outputs registered; new gain/resetb visible 1 cycle after the capture cycle of the last bit.
// - Invalid frame: addr >= NCH for opcodes 00/01/10 -> o_frame_err pulse, no register change. Broadcast never invalid.
// - o_cfg_done and o_frame_err never high together.
// - Reset mid-frame: partial frame discarded; STARTUP reruns; no partial update ever reaches outputs.
// - Timeout counter saturates; width clog2(TIMEOUT+1). Bit counter width clog2(FRAME_LEN+1).
// STRUCTURE
// - backend_defs.vh: opcode localparams (OP_WR_GAIN, OP_RST_REL, OP_RST_ASSERT, OP_BCAST), FSM state encodings.
// - Sub-module backend_sync_edge: 2-flop synchroniser + rising-edge detect for i_sclk, aligned sdin out; instantiated once.
// - Top holds FSM, shift register, counters, channel register arrays.
// TESTING
// - Params NCH=4, GW=3, ADDR_W=2, STARTUP_CYC=16, TIMEOUT=64, GAIN_RST=0; sclk period 8 i_clk.
// - Reset: hold low 5 cycles, release -> o_gain=12'h000, o_resetb=4'b0000, o_ready=0 for 16 cycles then 1.
// - Write gain: bits 0,0,1,0,1,0,1 (op00 addr2 data101) -> o_gain[8:6]=3'b101, other gains 0, one o_cfg_done pulse.
// - Reset release: op01 addr1 -> o_resetb=4'b0010; then op10 addr1 -> o_resetb=4'b0000.
// - Broadcast: op11 addr0 data011 -> o_gain=12'b011_011_011_011, one o_cfg_done.
// - Timeout/abort: 3 bits then 70 idle cycles -> one o_frame_err, outputs unchanged;
//   next full frame applies. Reset asserted mid-frame -> outputs to reset values, o_ready low 16 cycles.
// - NCH=3: op00 addr3 data111 -> o_frame_err pulse, o_gain unchanged, no o_cfg_done.

Source files
------------

// File: rtl/backend_multi_ch_pkg.sv
// rtl/backend_multi_ch_pkg.sv - opcodes and FSM states for the multi-channel backend config receiver
package backend_multi_ch_pkg;

    localparam logic [1:0] OP_WR_GAIN    = 2'b00;
    localparam logic [1:0] OP_RST_REL    = 2'b01;
    localparam logic [1:0] OP_RST_ASSERT = 2'b10;
    localparam logic [1:0] OP_BCAST      = 2'b11;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_APPLY   = 2'd3
    } state_t;

endpackage

// File: rtl/backend_sync_edge.sv
// rtl/backend_sync_edge.sv - 2-flop synchroniser with rising-edge detect for sclk and aligned sdin
module backend_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic sdin,
    output logic sclk_rise,
    output logic sdin_s
);

    logic [2:0] sclk_q;
    logic [1:0] sdin_q;

    // two synchroniser stages plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            sdin_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            sdin_q <= {sdin_q[0], sdin};
        end
    end

    // sdin_s sits at the same synchroniser depth as the sclk sample that flags the edge
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sdin_s    = sdin_q[1];

endmodule

// File: rtl/backend_multi_ch.sv
// rtl/backend_multi_ch.sv - serial config frame receiver driving NCH channels of gain and reset
module backend_multi_ch
    import backend_multi_ch_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int GW          = 3,
    parameter int ADDR_W      = 2,
    parameter int GAIN_RST    = 0,
    parameter int STARTUP_CYC = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                i_clk,
    input  logic                i_resetbAll,
    input  logic                i_sclk,
    input  logic                i_sdin,
    output logic                o_ready,
    output logic [NCH-1:0]      o_resetb,
    output logic [NCH*GW-1:0]   o_gain,
    output logic                o_cfg_done,
    output logic                o_frame_err
);

    localparam int FRAME_LEN = 2 + ADDR_W + GW;
    localparam int BCW       = $clog2(FRAME_LEN + 1);
    localparam int TCW       = $clog2(TIMEOUT + 1);
    localparam int SCW       = $clog2(STARTUP_CYC + 1);
    localparam logic [ADDR_W:0] NCH_L      = (ADDR_W + 1)'(NCH);
    localparam logic [GW-1:0]   GAIN_RST_V = GW'(GAIN_RST);

    state_t               state, state_nx;
    logic [FRAME_LEN-1:0] shreg;
    logic [BCW-1:0]       bit_cnt, bit_cnt_nx, bit_inc;
    logic [TCW-1:0]       to_cnt, to_cnt_nx;
    logic [SCW-1:0]       su_cnt, su_cnt_nx;
    logic                 shift_en, apply_en, to_err;
    logic                 sclk_rise, sdin_s;

    logic [1:0]           f_op;
    logic [ADDR_W-1:0]    f_addr;
    logic [GW-1:0]        f_data;
    logic                 frame_ok;

    backend_sync_edge u_sync (
        .clk       (i_clk),
        .rst_n     (i_resetbAll),
        .sclk      (i_sclk),
        .sdin      (i_sdin),
        .sclk_rise (sclk_rise),
        .sdin_s    (sdin_s)
    );

    // frame fields, MSB first: opcode, address, data
    assign f_op     = shreg[FRAME_LEN-1 -: 2];
    assign f_addr   = shreg[GW +: ADDR_W];
    assign f_data   = shreg[GW-1:0];
    assign frame_ok = (f_op == OP_BCAST) || ({1'b0, f_addr} < NCH_L);
    assign bit_inc  = bit_cnt + 1'b1;
    assign o_ready  = (state != ST_STARTUP);

    // state and counter registers
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            state   <= ST_STARTUP;
            bit_cnt <= '0;
            to_cnt  <= '0;
            su_cnt  <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            to_cnt  <= to_cnt_nx;
            su_cnt  <= su_cnt_nx;
        end
    end

    // next-state, counter updates and datapath strobes
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        to_cnt_nx  = to_cnt;
        su_cnt_nx  = '0;
        shift_en   = 1'b0;
        apply_en   = 1'b0;
        to_err     = 1'b0;
        case (state)
            ST_STARTUP: begin
                bit_cnt_nx = '0;
                to_cnt_nx  = '0;
                su_cnt_nx  = su_cnt + 1'b1;
                if (su_cnt == SCW'(STARTUP_CYC - 1)) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                to_cnt_nx = '0;
                if (sclk_rise) begin
                    shift_en   = 1'b1;
                    bit_cnt_nx = BCW'(1);
                    state_nx   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shift_en   = 1'b1;
                    to_cnt_nx  = '0;
                    bit_cnt_nx = bit_inc;
                    if (bit_inc == BCW'(FRAME_LEN)) begin
                        state_nx = ST_APPLY;
                    end
                end else if (to_cnt == TCW'(TIMEOUT)) begin
                    to_err     = 1'b1;
                    bit_cnt_nx = '0;
                    to_cnt_nx  = '0;
                    state_nx   = ST_IDLE;
                end else begin
                    to_cnt_nx = to_cnt + 1'b1;
                end
            end
            ST_APPLY: begin
                apply_en  = 1'b1;
                to_cnt_nx = '0;
                if (sclk_rise) begin
                    shift_en   = 1'b1;
                    bit_cnt_nx = BCW'(1);
                    state_nx   = ST_SHIFT;
                end else begin
                    bit_cnt_nx = '0;
                    state_nx   = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_STARTUP;
            end
        endcase
    end

    // serial shift register; a new first bit may arrive while APPLY decodes the old frame
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[FRAME_LEN-2:0], sdin_s};
        end
    end

    // channel registers and status pulses, updated only from a complete valid frame
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            o_gain      <= {NCH{GAIN_RST_V}};
            o_resetb    <= '0;
            o_cfg_done  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_cfg_done  <= 1'b0;
            o_frame_err <= to_err;
            if (apply_en) begin
                if (frame_ok) begin
                    o_cfg_done <= 1'b1;
                    for (int n = 0; n < NCH; n++) begin
                        if (f_op == OP_BCAST) begin
                            o_gain[n*GW +: GW] <= f_data;
                        end else if (f_addr == ADDR_W'(n)) begin
                            case (f_op)
                                OP_WR_GAIN:    o_gain[n*GW +: GW] <= f_data;
                                OP_RST_REL:    o_resetb[n] <= 1'b1;
                                OP_RST_ASSERT: o_resetb[n] <= 1'b0;
                                default:       o_resetb[n] <= o_resetb[n];
                            endcase
                        end
                    end
                end else begin
                    o_frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
